// File: rtl/pir_pkg.sv
// Constants and types shared by the PIR acquisition front-end and the alarm controller.
package pir_pkg;

  localparam int PIR_W                = 7;
  localparam int PIR_MOTION_THRESHOLD = 50;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pir_state_e;

  typedef logic [PIR_W-1:0] pir_reading_t;

  // Add one detector sample, sticking at full scale instead of wrapping.
  function automatic pir_reading_t pir_sat_add(input pir_reading_t acc, input logic bit_in);
    pir_reading_t res;
    if (acc == {PIR_W{1'b1}}) begin
      res = acc;
    end else begin
      res = acc + pir_reading_t'(bit_in);
    end
    return res;
  endfunction

endpackage

// File: rtl/pir_window_acc.sv
// One PIR channel: two-flop synchroniser, saturating window accumulator and
// the published reading register.
module pir_window_acc
  import pir_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_i,
  input  logic             win_end_i,
  input  logic             clear_i,
  input  logic             publish_i,
  output logic [PIR_W-1:0] reading_o
);

  logic [1:0]   sync_q;
  pir_reading_t acc_q;
  pir_reading_t acc_d;
  pir_reading_t reading_q;
  pir_reading_t reading_d;
  pir_reading_t sum_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      acc_q     <= '0;
      reading_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      acc_q     <= acc_d;
      reading_q <= reading_d;
    end
  end

  // The window-end sample is folded into the published value so no cycle is lost.
  always_comb begin
    sum_s     = pir_sat_add(acc_q, sync_q[1]);
    acc_d     = sum_s;
    reading_d = reading_q;
    if (clear_i) begin
      acc_d     = '0;
      reading_d = '0;
    end else begin
      if (win_end_i) begin
        acc_d = '0;
      end else begin
        acc_d = sum_s;
      end
      if (publish_i) begin
        reading_d = sum_s;
      end else begin
        reading_d = reading_q;
      end
    end
  end

  assign reading_o = reading_q;

endmodule

// File: rtl/pir_sensor_frontend.sv
// PIR acquisition front-end: OFF/WARMUP/RUN sequencing, shared window timing
// and three per-channel integrators producing 7-bit activity readings.
module pir_sensor_frontend
  import pir_pkg::*;
#(
  parameter int WINDOW         = 100,
  parameter int WARMUP_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       pir_raw,
  output logic [PIR_W-1:0] pir_sensor_1,
  output logic [PIR_W-1:0] pir_sensor_2,
  output logic [PIR_W-1:0] pir_sensor_3,
  output logic             sample_valid,
  output logic             ready
);

  localparam logic [6:0] WIN_LAST  = 7'(WINDOW - 1);
  localparam logic [3:0] WARM_LAST = 4'(WARMUP_WINDOWS - 1);

  pir_state_e state_q;
  pir_state_e state_d;
  logic [6:0] win_cnt_q;
  logic [6:0] win_cnt_d;
  logic [3:0] warm_q;
  logic [3:0] warm_d;
  logic       valid_q;
  logic       valid_d;
  logic       ready_q;
  logic       ready_d;

  logic       win_end_s;
  logic       clear_s;
  logic       publish_s;

  assign win_end_s = (state_q != ST_OFF) && (win_cnt_q == WIN_LAST);
  // Dropping enable clears everything at once, even mid-window or on a window end.
  assign clear_s   = (state_q == ST_OFF) || !enable;
  assign publish_s = (state_q == ST_RUN) && win_end_s && enable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      win_cnt_q <= 7'd0;
      warm_q    <= 4'd0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      warm_q    <= warm_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (WARMUP_WINDOWS == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (win_end_s && (warm_q == WARM_LAST)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARMUP;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    warm_d    = warm_q;
    if (clear_s) begin
      win_cnt_d = 7'd0;
      warm_d    = 4'd0;
    end else begin
      if (win_end_s) begin
        win_cnt_d = 7'd0;
      end else begin
        win_cnt_d = win_cnt_q + 7'd1;
      end
      if ((state_q == ST_WARMUP) && win_end_s) begin
        warm_d = warm_q + 4'd1;
      end else begin
        warm_d = warm_q;
      end
    end
  end

  always_comb begin
    ready_d = (state_d == ST_RUN);
    valid_d = publish_s;
  end

  pir_window_acc u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (pir_raw[0]),
    .win_end_i (win_end_s),
    .clear_i   (clear_s),
    .publish_i (publish_s),
    .reading_o (pir_sensor_1)
  );

  pir_window_acc u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (pir_raw[1]),
    .win_end_i (win_end_s),
    .clear_i   (clear_s),
    .publish_i (publish_s),
    .reading_o (pir_sensor_2)
  );

  pir_window_acc u_ch3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (pir_raw[2]),
    .win_end_i (win_end_s),
    .clear_i   (clear_s),
    .publish_i (publish_s),
    .reading_o (pir_sensor_3)
  );

  assign sample_valid = valid_q;
  assign ready        = ready_q;

endmodule

// File: tb/tb_pir_sensor_frontend.sv
// Directed bench for pir_sensor_frontend: default instance plus WINDOW=127 and
// no-warm-up instances.
module tb_pir_sensor_frontend;
  import pir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, en_b, en_c;
  logic [2:0] raw_a, raw_b, raw_c;
  logic [6:0] a_s1, a_s2, a_s3, b_s1, b_s2, b_s3, c_s1, c_s2, c_s3;
  logic       a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;

  int total = 0;
  int bad   = 0;

  pir_sensor_frontend u_dut (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .pir_raw(raw_a),
    .pir_sensor_1(a_s1), .pir_sensor_2(a_s2), .pir_sensor_3(a_s3),
    .sample_valid(a_valid), .ready(a_ready)
  );

  pir_sensor_frontend #(.WINDOW(127), .WARMUP_WINDOWS(1)) u_big (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .pir_raw(raw_b),
    .pir_sensor_1(b_s1), .pir_sensor_2(b_s2), .pir_sensor_3(b_s3),
    .sample_valid(b_valid), .ready(b_ready)
  );

  pir_sensor_frontend #(.WINDOW(100), .WARMUP_WINDOWS(0)) u_nowu (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .pir_raw(raw_c),
    .pir_sensor_1(c_s1), .pir_sensor_2(c_s2), .pir_sensor_3(c_s3),
    .sample_valid(c_valid), .ready(c_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int strobes = 0;
    int nonzero = 0;
    rst_n = 1'b0; en_a = 1'b1; raw_a = 3'b111;
    repeat (3) step();
    total++; if ({a_s1, a_s2, a_s3} !== 21'd0) begin bad++; $display("FAIL reset_readings got=%0h exp=0", {a_s1, a_s2, a_s3}); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", a_valid); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", a_ready); end
    rst_n = 1'b1; en_a = 1'b0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (a_valid) strobes++;
      if (a_ready || ({a_s1, a_s2, a_s3} != 21'd0)) nonzero++;
    end
    total++; if (strobes !== 0) begin bad++; $display("FAIL off_strobes got=%0d exp=0", strobes); end
    total++; if (nonzero !== 0) begin bad++; $display("FAIL off_outputs got=%0d exp=0", nonzero); end
  endtask

  task automatic test_warmup();
    int fr = -1, fv = -1, sv2 = -1, nv = 0, pre = -1;
    int r1 = 0, r2 = 0, r3 = 0;
    en_a = 1'b1;
    for (int k = 0; k <= 700; k++) begin
      step();
      if (k == 499) pre = int'(a_s1);
      if (a_ready && fr < 0) fr = k;
      if (a_valid) begin
        nv++;
        if (fv < 0) begin fv = k; r1 = int'(a_s1); r2 = int'(a_s2); r3 = int'(a_s3); end
        else if (sv2 < 0) sv2 = k;
      end
    end
    total++; if (fr !== 400) begin bad++; $display("FAIL warm_ready_rise got=%0d exp=400", fr); end
    total++; if (fv !== 500) begin bad++; $display("FAIL warm_first_valid got=%0d exp=500", fv); end
    total++; if (pre !== 0) begin bad++; $display("FAIL warm_pre_valid_reading got=%0d exp=0", pre); end
    total++; if (r1 !== 100) begin bad++; $display("FAIL full_ch1 got=%0d exp=100", r1); end
    total++; if (r2 !== 100) begin bad++; $display("FAIL full_ch2 got=%0d exp=100", r2); end
    total++; if (r3 !== 100) begin bad++; $display("FAIL full_ch3 got=%0d exp=100", r3); end
    total++; if (sv2 !== 600) begin bad++; $display("FAIL steady_period got=%0d exp=600", sv2); end
    total++; if (nv !== 3) begin bad++; $display("FAIL valid_count got=%0d exp=3", nv); end
  endtask

  task automatic test_partial();
    int p = 0;
    int nchk = 0;
    for (int c = 0; c < 300; c++) begin
      raw_a[0] = (p < 60);
      raw_a[1] = 1'b0;
      raw_a[2] = (p % 2) == 1;
      p = (p + 1) % 100;
      step();
      if (a_valid && c >= 150) begin
        nchk++;
        total++; if (a_s1 !== 7'd60) begin bad++; $display("FAIL partial_ch1 got=%0d exp=60", a_s1); end
        total++; if (a_s2 !== 7'd0) begin bad++; $display("FAIL partial_ch2 got=%0d exp=0", a_s2); end
        total++; if (a_s3 !== 7'd50) begin bad++; $display("FAIL partial_ch3 got=%0d exp=50", a_s3); end
        total++; if (!(int'(a_s3) >= PIR_MOTION_THRESHOLD)) begin bad++; $display("FAIL partial_ch3_motion got=%0d exp>=50", a_s3); end
      end
    end
    total++; if (nchk !== 2) begin bad++; $display("FAIL partial_strobes got=%0d exp=2", nchk); end
    raw_a = 3'b111;
  endtask

  task automatic test_disable_mid();
    int found = 0, nv_warm = 0, fr = -1, fv = -1, r1 = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      step();
      if (a_valid) found = 1;
    end
    total++; if (found !== 1) begin bad++; $display("FAIL dis_wait_valid got=%0d exp=1", found); end
    repeat (37) step();
    en_a = 1'b0;
    step();
    total++; if ({a_s1, a_s2, a_s3} !== 21'd0) begin bad++; $display("FAIL dis_readings got=%0h exp=0", {a_s1, a_s2, a_s3}); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL dis_ready got=%0b exp=0", a_ready); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL dis_valid got=%0b exp=0", a_valid); end
    repeat (5) step();
    en_a = 1'b1;
    for (int k = 0; k <= 500; k++) begin
      step();
      if (a_valid && k < 400) nv_warm++;
      if (a_ready && fr < 0) fr = k;
      if (a_valid && fv < 0) begin fv = k; r1 = int'(a_s1); end
    end
    total++; if (nv_warm !== 0) begin bad++; $display("FAIL rewarm_strobes got=%0d exp=0", nv_warm); end
    total++; if (fr !== 400) begin bad++; $display("FAIL rewarm_ready got=%0d exp=400", fr); end
    total++; if (fv !== 500) begin bad++; $display("FAIL rewarm_first_valid got=%0d exp=500", fv); end
    total++; if (r1 !== 100) begin bad++; $display("FAIL rewarm_ch1 got=%0d exp=100", r1); end
  endtask

  task automatic test_reset_run();
    int fr = -1, fv = -1, r3 = 0;
    total++; if (a_s2 !== 7'd100) begin bad++; $display("FAIL rst_pre_reading got=%0d exp=100", a_s2); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if ({a_s1, a_s2, a_s3} !== 21'd0) begin bad++; $display("FAIL rstrun_readings got=%0h exp=0", {a_s1, a_s2, a_s3}); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rstrun_ready got=%0b exp=0", a_ready); end
    for (int k = 0; k <= 500; k++) begin
      step();
      if (a_ready && fr < 0) fr = k;
      if (a_valid && fv < 0) begin fv = k; r3 = int'(a_s3); end
    end
    total++; if (fr !== 400) begin bad++; $display("FAIL rstrun_ready_rise got=%0d exp=400", fr); end
    total++; if (fv !== 500) begin bad++; $display("FAIL rstrun_first_valid got=%0d exp=500", fv); end
    total++; if (r3 !== 100) begin bad++; $display("FAIL rstrun_ch3 got=%0d exp=100", r3); end
  endtask

  task automatic test_drop_at_window_end();
    repeat (99) step();
    total++; if (a_s1 !== 7'd100) begin bad++; $display("FAIL hold_reading got=%0d exp=100", a_s1); end
    en_a = 1'b0;
    step();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL winend_drop_valid got=%0b exp=0", a_valid); end
    total++; if (a_s1 !== 7'd0) begin bad++; $display("FAIL winend_drop_reading got=%0d exp=0", a_s1); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL winend_drop_ready got=%0b exp=0", a_ready); end
  endtask

  task automatic test_window127();
    int fr = -1, fv = -1, sv2 = -1, r1 = 0, r2 = 0;
    en_b = 1'b1;
    for (int k = 0; k <= 400; k++) begin
      step();
      if (b_ready && fr < 0) fr = k;
      if (b_valid) begin
        if (fv < 0) begin fv = k; r1 = int'(b_s1); end
        else if (sv2 < 0) begin sv2 = k; r2 = int'(b_s3); end
      end
    end
    total++; if (fr !== 127) begin bad++; $display("FAIL w127_ready got=%0d exp=127", fr); end
    total++; if (fv !== 254) begin bad++; $display("FAIL w127_first_valid got=%0d exp=254", fv); end
    total++; if (r1 !== 127) begin bad++; $display("FAIL w127_ch1 got=%0d exp=127", r1); end
    total++; if (sv2 !== 381) begin bad++; $display("FAIL w127_second_valid got=%0d exp=381", sv2); end
    total++; if (r2 !== 127) begin bad++; $display("FAIL w127_ch3 got=%0d exp=127", r2); end
    en_b = 1'b0;
  endtask

  task automatic test_no_warmup();
    int fr = -1, fv = -1, r1 = 0, r2 = -1, r3 = 0;
    en_c = 1'b1;
    for (int k = 0; k <= 150; k++) begin
      step();
      if (c_ready && fr < 0) fr = k;
      if (c_valid && fv < 0) begin fv = k; r1 = int'(c_s1); r2 = int'(c_s2); r3 = int'(c_s3); end
    end
    total++; if (fr !== 0) begin bad++; $display("FAIL nowu_ready got=%0d exp=0", fr); end
    total++; if (fv !== 100) begin bad++; $display("FAIL nowu_first_valid got=%0d exp=100", fv); end
    total++; if (r1 !== 100) begin bad++; $display("FAIL nowu_ch1 got=%0d exp=100", r1); end
    total++; if (r2 !== 0) begin bad++; $display("FAIL nowu_ch2 got=%0d exp=0", r2); end
    total++; if (r3 !== 100) begin bad++; $display("FAIL nowu_ch3 got=%0d exp=100", r3); end
    en_c = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    raw_a = 3'b111; raw_b = 3'b111; raw_c = 3'b101;
    test_reset();
    test_warmup();
    test_partial();
    test_disable_mid();
    test_reset_run();
    test_drop_at_window_end();
    test_window127();
    test_no_warmup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pir_sensor_frontend.md
# pir_sensor_frontend

Acquisition front-end that produces the three 7-bit PIR readings consumed by the motion-alarm controller. It takes three raw 1-bit PIR detector outputs, synchronises them, integrates each over a fixed sample window, and publishes a per-window activity count (0..WINDOW). It also runs a warm-up phase after enable and pulses a strobe on each published sample. The block sits between the board PIR pins and the alarm controller's `pir_sensor_1..3` inputs; a reading of 50 or more means motion.

## Interface
- `WINDOW`, 100, clock cycles per sample window; legal 2..127, so a full-high window reads exactly `WINDOW`.
- `WARMUP_WINDOWS`, 4, full windows discarded after enable before the first published sample; legal 0..15.
- `clk`  input  1  single system clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `enable`  input  1  level; 1 = acquire, 0 = off. Driven from the same source as the controller's `turn`.
- `pir_raw`  input  3  asynchronous raw detector outputs; bit i = sensor i+1.
- `pir_sensor_1`, `pir_sensor_2`, `pir_sensor_3`  output  7 each  registered reading of the last completed window.
- `sample_valid`  output  1  one-cycle pulse in the cycle new readings first appear.
- `ready`  output  1  high while in RUN, i.e. warm-up is complete.

## Operation
- **Synchroniser:** two flops per `pir_raw` bit. Only the synchronised bit `s[i]` feeds the accumulators.
- **State machine:** three states, OFF, WARMUP and RUN.
- **OFF:**
  - Window counter, warm-up counter, accumulators and all outputs are held at 0.
  - `enable=1` moves to WARMUP next cycle, or to RUN directly if `WARMUP_WINDOWS=0`.
- **WARMUP:**
  - Windows run normally, but results are discarded and outputs stay 0.
  - The warm-up counter increments at each window end.
  - At the end of window number `WARMUP_WINDOWS`, go to RUN. The window starting that cycle is the first published window.
- **RUN:**
  - At each window end, each output loads its channel's final count.
  - `sample_valid` pulses for that one cycle.
  - `ready=1`.
- **Leaving any state:**
  - `enable=0` in any state goes to OFF next cycle, clearing outputs, `ready` and all counters, including mid-window. A partial window is never published.
  - Re-enabling always repeats warm-up.
- **Window counter:** counts 0..`WINDOW-1`, then wraps to 0. Window end is the cycle in which the counter equals `WINDOW-1`.
- **Accumulator:** per channel, 7 bits. Each cycle it adds `s[i]`.
  - At window end, the published value is acc + `s[i]` of that same cycle, so all `WINDOW` cycles are counted.
  - At window end the accumulator reloads 0, and the new window's first sample lands the next cycle.
  - The value saturates at 127; with legal `WINDOW` saturation cannot be reached, and it exists as a guard only.
- **Output hold:** outputs hold their value between window ends.
- **Simultaneous events:** `rst_n=0` has priority over everything. Next, `enable=0` beats a window end in the same cycle: no strobe, outputs cleared.

## Timing
- **Reset:** after a clock edge with `rst_n=0`, the state is OFF and `pir_sensor_1..3=0`, `sample_valid=0`, `ready=0`. Synchroniser flops are also 0. Reset mid-RUN behaves identically.
- **Input latency:** `pir_raw` edge to accumulator effect is 2 cycles from the synchroniser, plus 1 for the accumulate.
- **First published sample:** enable asserted at cycle E (first edge seeing it), so WARMUP starts at E+1.
  - The first `sample_valid` is at cycle E+1 + (`WARMUP_WINDOWS`+1)·`WINDOW`.
  - Counting to that point: the first WARMUP/RUN window counts cycle E+1 as index 0, and the outputs update the cycle after the window-end edge.
  - `ready` rises at E+1 + `WARMUP_WINDOWS`·`WINDOW`.
- **Steady state:** a `sample_valid` every `WINDOW` cycles exactly. The pulse is one cycle wide and coincides with the new output values.
- **Disable:** `enable` falls, and outputs read 0 one cycle later.

## Structure
- **Shared package `pir_pkg`:** state encoding for OFF/WARMUP/RUN, `PIR_W=7` (reading width), and `PIR_MOTION_THRESHOLD=50`. The alarm controller imports the same package constants.
- **Sub-module `pir_window_acc`:** one channel, comprising the synchroniser, accumulator with saturation, and output register. It takes a shared `win_end`, a `clear` and a `publish` from the parent. It is instantiated three times.
- **Parent:** holds the state machine, window counter and warm-up counter.

## Test plan
- **Reset/off:** assert `rst_n=0` for 3 cycles with `pir_raw=3'b111` and `enable=1` → all outputs 0. Release with `enable=0` → outputs stay 0 and no strobe for 500 cycles.
- **Warm-up and full scale:** defaults, `pir_raw=3'b111`, enable at E → `ready` rises at E+401. First `sample_valid` at E+501 with all readings 100. Then pulses every 100 cycles.
- **Partial duty:** after `ready`, drive ch1 high 60 of each 100 window cycles, ch2 constant 0, ch3 toggling every cycle. Readings must be ch1=60, ch2=0, ch3=50 (ch3 ≥ threshold).
- **Disable mid-window:** drop `enable` 37 cycles into a RUN window → next cycle outputs 0, `ready=0`, and no strobe. Re-enable → warm-up repeats: 4 windows with no strobe.
- **Reset mid-RUN:** a 1-cycle `rst_n=0` while readings are 100 → next cycle all 0 and OFF. Holding `enable` high restarts warm-up.
- **Boundaries:**
  - `WINDOW=127`, all high → readings 127, with no wrap to 0.
  - `WARMUP_WINDOWS=0` → `ready` one cycle after enable, and first strobe `WINDOW` cycles later.
  - `enable=0` on a window-end cycle → no `sample_valid`.
